// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register: small in-order FIFO with skid, bubble insertion and flush
module pipe_stage_reg #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 16,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic                       ctrl_sel,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   // storage entries; contents only matter once written, so no reset
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [CTRL_W-1:0] r_mem_ctrl [DEPTH];

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [OCC_W-1:0]  r_occ;

   // head copy kept in registers so out_data can hold the last head after a pop
   logic [DATA_W-1:0] r_head_data;
   logic [CTRL_W-1:0] r_head_ctrl;

   logic              w_push;
   logic              w_pop;
   logic [CTRL_W-1:0] w_wr_ctrl;
   logic [PTR_W-1:0]  w_rd_next;
   logic [OCC_W-1:0]  w_occ_next;
   logic              w_head_load;
   logic              w_head_from_in;
   logic [DATA_W-1:0] w_head_data;
   logic [CTRL_W-1:0] w_head_ctrl;

   // pointers wrap modulo DEPTH, which need not be a power of two
   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // a full stage still accepts when the head leaves in the same cycle
   assign in_ready  = (r_occ < FULL_OCC) | out_ready;
   assign out_valid = (r_occ != '0);
   assign occupancy = r_occ;
   assign out_data  = r_head_data;
   assign out_ctrl  = out_valid ? r_head_ctrl : '0;

   assign w_push    = in_valid & in_ready & ~flush;
   assign w_pop     = out_valid & out_ready & ~flush;
   assign w_wr_ctrl = ctrl_sel ? in_ctrl : '0;
   assign w_rd_next = w_pop ? f_inc(r_rd_ptr) : r_rd_ptr;

   // occupancy bookkeeping; a simultaneous push and pop leaves it unchanged
   always_comb begin
      w_occ_next = r_occ;
      if (w_push && !w_pop) begin
         w_occ_next = r_occ + 1'b1;
      end else if (!w_push && w_pop) begin
         w_occ_next = r_occ - 1'b1;
      end
   end

   // the head changes when it is consumed with more entries behind it, or when an empty stage is filled;
   // the new head is the incoming entry exactly when it lands in the slot the read pointer moves to
   always_comb begin
      w_head_load    = (w_pop && (w_occ_next != '0)) || (w_push && !out_valid);
      w_head_from_in = w_push && (r_wr_ptr == w_rd_next);
      w_head_data    = r_mem_data[w_rd_next];
      w_head_ctrl    = r_mem_ctrl[w_rd_next];
      if (w_head_from_in) begin
         w_head_data = in_data;
         w_head_ctrl = w_wr_ctrl;
      end
   end

   // pointer and occupancy state; flush empties the stage, reset wins over everything
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= f_inc(r_wr_ptr);
         end
         r_rd_ptr <= w_rd_next;
         r_occ    <= w_occ_next;
      end
   end

   // entry write; a bubble keeps the payload but stores zero control
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= in_data;
         r_mem_ctrl[r_wr_ptr] <= w_wr_ctrl;
      end
   end

   // head register; held across empty periods and flushes, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head_data <= '0;
         r_head_ctrl <= '0;
      end else if (!flush && w_head_load) begin
         r_head_data <= w_head_data;
         r_head_ctrl <= w_head_ctrl;
      end
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, 96, payload width (rs1 data, rs2 data, immediate).
REQ-002 Parameter: CTRL_W, 16, control-field width (write enables, ALU select, operand selects, WB select, register indices).
REQ-003 Parameter: DEPTH, 2, number of storage entries (main + skid); legal values 2..4.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 Port: in_valid  in  1  upstream entry present.
REQ-007 Port: in_ready  out  1  stage can accept this cycle.
REQ-008 Port: in_data  in  DATA_W  upstream payload.
REQ-009 Port: in_ctrl  in  CTRL_W  upstream control fields.
REQ-010 Port: ctrl_sel  in  1  1 = capture in_ctrl; 0 = capture zero control (bubble insertion).
REQ-011 Port: flush  in  1  discard all held and incoming entries.
REQ-012 Port: out_valid  out  1  head entry present.
REQ-013 Port: out_ready  in  1  downstream consumes head this cycle.
REQ-014 Port: out_data  out  DATA_W  head payload.
REQ-015 Port: out_ctrl  out  CTRL_W  head control; forced 0 whenever out_valid = 0.
REQ-016 Port: occupancy  out  $clog2(DEPTH+1)  number of held entries.

Function
REQ-017 Storage: in-order FIFO of DEPTH entries, each {data, ctrl}; head drives out_data/out_ctrl.
REQ-018 Accept: push when in_valid & in_ready & ~flush.
REQ-019 Consume: pop when out_valid & out_ready & ~flush.
REQ-020 in_ready = (occupancy < DEPTH) | out_ready; combinational path from out_ready allowed only in this term.
REQ-021 Latency: entry pushed in cycle N appears at outputs in cycle N+1 when stage was empty; throughput one entry per cycle under continuous in_valid & out_ready.
REQ-022 Simultaneous push and pop: occupancy unchanged; full stage (occupancy = DEPTH) with out_ready = 1 still accepts.
REQ-023 Push with ctrl_sel = 0: stored ctrl = 0, data stored unchanged, entry counts as valid.
REQ-024 Flush: next cycle occupancy = 0, out_valid = 0, out_ctrl = 0; same-cycle push dropped; same-cycle pop not counted as consumed; flush overrides push, pop and ctrl_sel.
REQ-025 out_data when out_valid = 0: holds last head value (not cleared except by reset).
REQ-026 Empty stage: out_valid = 0; pop ignored; push with out_ready = 1 still stores (no combinational bypass).
REQ-027 Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH nor underflows below 0.
REQ-028 No entry reordered, duplicated or lost except by flush or reset.

Reset
REQ-029 reset = 1 at rising clk: occupancy = 0, out_valid = 0, out_data = 0, out_ctrl = 0, pointers = 0; in_ready = 1 in the following cycle.
REQ-030 reset overrides flush, push and pop; mid-operation reset discards all held entries.
REQ-031 Outputs are undefined only before the first reset edge; no async path from reset.

Verification
REQ-032 Stream: DEPTH=2, out_ready=1, push data 0x1..0x8 back-to-back -> outputs 0x1..0x8 in order, one per cycle, first at cycle+1, occupancy stays <=1.
REQ-033 Backpressure: out_ready=0, push 0xA,0xB -> occupancy=2, in_ready=0 (out_ready=0); third push 0xC held; raise out_ready -> 0xA,0xB,0xC in order, nothing dropped.
REQ-034 Bubble: push ctrl=0xFFFF data=0x55 with ctrl_sel=0 -> out_valid=1, out_ctrl=0x0000, out_data=0x55.
REQ-035 Flush: occupancy=2, flush=1 with concurrent push 0xD -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0xD never appears.
REQ-036 Reset mid-stream: occupancy=2, reset=1 with flush=1 and push -> next cycle all outputs 0, in_ready=1; next push 0xE appears one cycle later.
REQ-037 Wrap: DEPTH=3, 10 push/pop cycles with random out_ready -> scoreboard matches order; occupancy within 0..3 throughout.
